// File: rtl/nibble_serial_add16.sv
// 16-bit adder/subtractor that pushes one nibble per cycle through a single
// 4-bit adder, LSB nibble first, with a fixed five-cycle start-to-done latency.

module adder4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] y_o,
    output logic       c_o
);
    assign {c_o, y_o} = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, c_i};
endmodule

// state | meaning
// IDLE  | waiting for start_i
// RUN   | one nibble per cycle through the adder, busy_o high
// FIN   | completion cycle, done_o high, start_i accepted back-to-back
module nibble_serial_add16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        sub_i,
    input  logic [15:0] op_a_i,
    input  logic [15:0] op_b_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] result_o,
    output logic        c_out_o,
    output logic        ovf_o,
    output logic        zero_o
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;

    state_e      state_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [11:0] acc_q;
    logic [15:0] result_q;
    logic [1:0]  idx_q;
    logic        carry_q;
    logic        c_out_q;
    logic        ovf_q;
    logic        busy_q;
    logic        done_q;

    logic [3:0]  a_nib;
    logic [3:0]  b_nib;
    logic [3:0]  sum_nib;
    logic        sum_co;

    assign a_nib = a_q[{idx_q, 2'b00} +: 4];
    assign b_nib = b_q[{idx_q, 2'b00} +: 4];

    adder4 u_adder4 (
        .a_i (a_nib),
        .b_i (b_nib),
        .c_i (carry_q),
        .y_o (sum_nib),
        .c_o (sum_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            c_out_q  <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, FIN: begin
                    if (start_i) begin
                        a_q     <= op_a_i;
                        b_q     <= op_b_i ^ {16{sub_i}};
                        carry_q <= sub_i;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    carry_q <= sum_co;
                    idx_q   <= idx_q + 2'd1;
                    if (idx_q != 2'd3) begin
                        acc_q[{idx_q, 2'b00} +: 4] <= sum_nib;
                    end else begin
                        // Top nibble goes straight to the visible result so
                        // partial sums never show up on result_o.
                        result_q <= {sum_nib, acc_q};
                        c_out_q  <= sum_co;
                        ovf_q    <= (a_q[15] == b_q[15]) && (sum_nib[3] != a_q[15]);
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= FIN;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;
    assign c_out_o  = c_out_q;
    assign ovf_o    = ovf_q;
    assign zero_o   = (result_q == 16'h0000);
endmodule

// File: tb/tb_nibble_serial_add16.sv
// Bench for nibble_serial_add16: vector table plus random operands through a
// scoreboard, and hand sequences for latency, handshake and mid-op reset.

module tb_nibble_serial_add16;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        sub_i = 1'b0;
    logic [15:0] op_a_i = '0;
    logic [15:0] op_b_i = '0;
    logic        busy_o;
    logic        done_o;
    logic [15:0] result_o;
    logic        c_out_o;
    logic        ovf_o;
    logic        zero_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] res;
        logic        c;
        logic        ovf;
        logic        z;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        exp_t        e;
    } vec_t;

    exp_t sb[$];

    nibble_serial_add16 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_i),
        .sub_i    (sub_i),
        .op_a_i   (op_a_i),
        .op_b_i   (op_b_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o),
        .c_out_o  (c_out_o),
        .ovf_o    (ovf_o),
        .zero_o   (zero_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic sub);
        exp_t        e;
        logic [15:0] bm;
        logic [16:0] s;
        bm    = sub ? ~b : b;
        s     = {1'b0, a} + {1'b0, bm} + {16'h0000, sub};
        e.res = s[15:0];
        e.c   = s[16];
        e.ovf = (a[15] == bm[15]) && (s[15] != a[15]);
        e.z   = (s[15:0] == 16'h0000);
        return e;
    endfunction

    always @(negedge clk) begin
        if (done_o) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done_o=1 with no operation pending at %0t", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", 32'(result_o), 32'(e.res));
                chk("c_out", 32'(c_out_o), 32'(e.c));
                chk("ovf", 32'(ovf_o), 32'(e.ovf));
                chk("zero", 32'(zero_o), 32'(e.z));
            end
        end
    end

    task automatic drive_start(input logic [15:0] a, input logic [15:0] b, input logic sub);
        op_a_i  = a;
        op_b_i  = b;
        sub_i   = sub;
        start_i = 1'b1;
    endtask

    task automatic wait_done(input int n0, output int n);
        n = n0;
        while (!done_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!done_o) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done_o within %0d cycles", n);
        end
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sub, input exp_t e);
        int n;
        @(negedge clk);
        drive_start(a, b, sub);
        sb.push_back(e);
        @(negedge clk);
        start_i = 1'b0;
        wait_done(1, n);
        chk("latency", 32'(n), 32'd5);
    endtask

    initial begin
        vec_t vecs[8];
        int   n;
        exp_t e;

        vecs[0] = '{16'h1234, 16'h0FCC, 1'b0, '{16'h2200, 1'b0, 1'b0, 1'b0}};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, '{16'h0000, 1'b1, 1'b0, 1'b1}};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, '{16'h8000, 1'b0, 1'b1, 1'b0}};
        vecs[3] = '{16'h0005, 16'h0007, 1'b1, '{16'hFFFE, 1'b0, 1'b0, 1'b0}};
        vecs[4] = '{16'h8000, 16'h0001, 1'b1, '{16'h7FFF, 1'b1, 1'b1, 1'b0}};
        vecs[5] = '{16'h0007, 16'h0007, 1'b1, '{16'h0000, 1'b1, 1'b0, 1'b1}};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, '{16'h0000, 1'b1, 1'b1, 1'b1}};
        vecs[7] = '{16'hABCD, 16'h1111, 1'b0, '{16'hBCDE, 1'b0, 1'b0, 1'b0}};

        #1;
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_result", 32'(result_o), 32'h0);
        chk("rst_c_out", 32'(c_out_o), 32'd0);
        chk("rst_ovf", 32'(ovf_o), 32'd0);
        chk("rst_zero", 32'(zero_o), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].e);

        // Busy/done timing, with the previous result held during RUN.
        @(negedge clk);
        drive_start(16'h1234, 16'h0FCC, 1'b0);
        sb.push_back('{16'h2200, 1'b0, 1'b0, 1'b0});
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start_i = 1'b0;
            chk("run_busy", 32'(busy_o), 32'd1);
            chk("run_done", 32'(done_o), 32'd0);
            chk("run_hold", 32'(result_o), 32'(vecs[7].e.res));
        end
        @(negedge clk);
        chk("fin_done", 32'(done_o), 32'd1);
        chk("fin_busy", 32'(busy_o), 32'd0);
        @(negedge clk);
        chk("done_pulse", 32'(done_o), 32'd0);
        chk("idle_busy", 32'(busy_o), 32'd0);
        chk("idle_hold", 32'(result_o), 32'h2200);

        // START while busy is ignored; START in FIN is accepted back-to-back.
        @(negedge clk);
        drive_start(16'h1111, 16'h2222, 1'b0);
        sb.push_back('{16'h3333, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        drive_start(16'hFFFF, 16'hFFFF, 1'b1);
        @(negedge clk);
        drive_start(16'h8000, 16'h8000, 1'b0);
        @(negedge clk);
        start_i = 1'b0;
        chk("ignore_busy", 32'(busy_o), 32'd1);
        @(negedge clk);
        chk("hs_done1", 32'(done_o), 32'd1);
        drive_start(16'h0100, 16'h0001, 1'b1);
        sb.push_back('{16'h00FF, 1'b1, 1'b0, 1'b0});
        @(negedge clk);
        start_i = 1'b0;
        chk("b2b_busy", 32'(busy_o), 32'd1);
        wait_done(1, n);
        chk("b2b_spacing", 32'(n), 32'd5);

        for (int r = 0; r < 6; r++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            logic        rs;
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom_range(0, 1));
            run_op(ra, rb, rs, model(ra, rb, rs));
        end

        // Reset while nibble index 2 is being processed.
        @(negedge clk);
        drive_start(16'h4321, 16'h1234, 1'b0);
        sb.push_back(model(16'h4321, 16'h1234, 1'b0));
        @(posedge clk);
        #1 start_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        sb.delete();
        chk("mid_rst_busy", 32'(busy_o), 32'd0);
        chk("mid_rst_done", 32'(done_o), 32'd0);
        chk("mid_rst_result", 32'(result_o), 32'h0);
        chk("mid_rst_c_out", 32'(c_out_o), 32'd0);
        chk("mid_rst_ovf", 32'(ovf_o), 32'd0);
        chk("mid_rst_zero", 32'(zero_o), 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        drive_start(16'h0001, 16'h0001, 1'b0);
        sb.push_back('{16'h0002, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        start_i = 1'b0;
        wait_done(1, n);
        chk("post_rst_latency", 32'(n), 32'd5);

        repeat (8) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/nibble_serial_add16.md
NIBBLE_SERIAL_ADD16 -- requirements
Module: nibble_serial_add16

Interface
REQ-001 Parameters SHALL be none; width fixed at 16 bits, nibble width 4.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST_N  input  1  reset, asynchronous assert, active-low.
REQ-004 START  input  1  request; sampled only when BUSY=0.
REQ-005 SUB  input  1  0 = A+B, 1 = A-B; sampled with START.
REQ-006 OP_A  input  16  operand A; sampled with START.
REQ-007 OP_B  input  16  operand B; sampled with START.
REQ-008 BUSY  output  1  high while nibbles are being processed.
REQ-009 DONE  output  1  one-cycle completion pulse.
REQ-010 RESULT  output  16  last completed sum/difference.
REQ-011 C_OUT  output  1  carry out of bit 15 of last operation (SUB: 1 = no borrow).
REQ-012 OVF  output  1  two's-complement overflow of last operation.
REQ-013 ZERO  output  1  RESULT == 16'h0000.

Function
REQ-014 Block SHALL contain exactly one ADDER4 instance as its only arithmetic element; all additions pass through it one nibble per cycle.
REQ-015 FSM states SHALL be IDLE, RUN, FIN; BUSY=1 only in RUN, DONE=1 only in FIN.
REQ-016 Edge k with START=1 and state IDLE or FIN: capture OP_A, OP_B^{16{SUB}}, carry register := SUB, nibble index := 0, go to RUN.
REQ-017 In RUN, each edge SHALL feed nibble i of A, nibble i of modified B, and carry register to ADDER4, store Y into result nibble i, load carry register from ADDER4 C_out, increment i (2-bit).
REQ-018 Nibble order SHALL be LSB first: i=0 bits 3:0 through i=3 bits 15:12.
REQ-019 At the edge processing i=3 (edge k+4): RESULT, C_OUT, OVF, ZERO SHALL update together; state := FIN.
REQ-020 Latency SHALL be fixed: DONE high during the cycle after edge k+4, for exactly one cycle; FIN -> IDLE unless START=1 (then RUN, back-to-back).
REQ-021 START while BUSY=1 SHALL be ignored; captured operands and SUB SHALL not change mid-operation.
REQ-022 OVF SHALL equal (A[15] == Bmod[15]) && (RESULT[15] != A[15]), Bmod = modified B.
REQ-023 ZERO SHALL be derived from the registered RESULT, not from partial sums.
REQ-024 RESULT, C_OUT, OVF, ZERO SHALL hold their values between completions; partial sums SHALL not be visible on RESULT during RUN.
REQ-025 Arithmetic SHALL be modulo 2^16; no saturation.

Reset
REQ-026 RST_N=0 SHALL immediately force state IDLE, BUSY=0, DONE=0, RESULT=16'h0000, C_OUT=0, OVF=0, ZERO=1, index=0, carry register=0.
REQ-027 Reset during RUN SHALL abandon the operation with no DONE pulse; first START after RST_N rises SHALL behave as from power-up.
REQ-028 Deassertion of RST_N SHALL take effect at the next CLK edge; START sampled on that edge SHALL be honoured.

Verification
REQ-029 Add: OP_A=16'h1234, OP_B=16'h0FCC, SUB=0, START at edge k -> BUSY high k+1..k+4, DONE high after edge k+4, RESULT=16'h2200, C_OUT=0, OVF=0, ZERO=0.
REQ-030 Wrap: 16'hFFFF + 16'h0001 -> RESULT=16'h0000, C_OUT=1, ZERO=1, OVF=0.
REQ-031 Signed overflow: 16'h7FFF + 16'h0001 -> RESULT=16'h8000, OVF=1, C_OUT=0.
REQ-032 Subtract: 16'h0005 - 16'h0007 (SUB=1) -> RESULT=16'hFFFE, C_OUT=0, OVF=0, ZERO=0.
REQ-033 Handshake: START with new operands on edges k+2 and k+3 -> ignored, result of first op unchanged; START during FIN cycle -> second op accepted, its DONE exactly 5 cycles after first DONE.
REQ-034 Reset mid-op: RST_N=0 while index=2 -> outputs at REQ-026 values asynchronously, no DONE; subsequent 16'h0001+16'h0001 -> RESULT=16'h0002.
